// File: rtl/output_select_sequencer.sv
// Output select sequencer: latches one Y0/Y1/first/last configuration, then
// steps the 16-bit word-select pattern from first to last (inclusive, with
// wrap-around) and offers each candidate to the hash core over valid/ready.
module output_select_sequencer #(
  parameter int unsigned SEL_WIDTH  = 16,
  parameter int unsigned WORD_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [WORD_WIDTH-1:0] Y0_i,
  input  logic [WORD_WIDTH-1:0] Y1_i,
  input  logic [SEL_WIDTH-1:0]  first_bits_i,
  input  logic [SEL_WIDTH-1:0]  last_bits_i,
  input  logic                  abort_i,
  output logic [WORD_WIDTH-1:0] Y0_o,
  output logic [WORD_WIDTH-1:0] Y1_o,
  output logic [SEL_WIDTH-1:0]  Y1_bits_o,
  output logic                  cand_valid_o,
  input  logic                  cand_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [SEL_WIDTH:0]    count_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e                state_q;
  logic [WORD_WIDTH-1:0] y0_q;
  logic [WORD_WIDTH-1:0] y1_q;
  logic [SEL_WIDTH-1:0]  bits_q;
  logic [SEL_WIDTH-1:0]  last_q;
  logic [SEL_WIDTH:0]    count_q;
  logic                  done_q;

  logic                  accept;
  logic                  at_last;
  logic [SEL_WIDTH-1:0]  bits_inc;
  logic [SEL_WIDTH:0]    count_inc;

  // Handshake and next-pattern decode; the increment wraps modulo 2^SEL_WIDTH.
  always_comb begin
    accept    = (state_q == StRun) && cand_ready_i;
    at_last   = (bits_q == last_q);
    bits_inc  = bits_q + SEL_WIDTH'(1);
    count_inc = count_q + (SEL_WIDTH + 1)'(1);
  end

  // Sequencer FSM with all registered outputs; abort beats the DONE transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      y0_q    <= '0;
      y1_q    <= '0;
      bits_q  <= '0;
      last_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_valid_i) begin
            y0_q    <= Y0_i;
            y1_q    <= Y1_i;
            bits_q  <= first_bits_i;
            last_q  <= last_bits_i;
            count_q <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (accept) begin
            count_q <= count_inc;
            if (!at_last) begin
              bits_q <= bits_inc;
            end
          end
          if (abort_i) begin
            state_q <= StIdle;
          end else if (accept && at_last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Handshake flags decode straight from state so the first candidate is
  // valid the cycle after configuration.
  always_comb begin
    cfg_ready_o  = (state_q == StIdle);
    cand_valid_o = (state_q == StRun);
    busy_o       = (state_q == StRun);
  end

  assign Y0_o      = y0_q;
  assign Y1_o      = y1_q;
  assign Y1_bits_o = bits_q;
  assign count_o   = count_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_output_select_sequencer.sv
// Directed bench for output_select_sequencer: basic run, backpressure, wrap,
// single pattern, full range, abort and reset during a run.
module tb_output_select_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [63:0] y0_in;
  logic [63:0] y1_in;
  logic [15:0] first_bits;
  logic [15:0] last_bits;
  logic        abort;
  logic [63:0] y0_out;
  logic [63:0] y1_out;
  logic [15:0] y1_bits;
  logic        cand_valid;
  logic        cand_ready;
  logic        busy;
  logic        done;
  logic [16:0] count;

  int n_cmp;
  int n_err;

  output_select_sequencer #(
    .SEL_WIDTH (16),
    .WORD_WIDTH(64)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .Y0_i        (y0_in),
    .Y1_i        (y1_in),
    .first_bits_i(first_bits),
    .last_bits_i (last_bits),
    .abort_i     (abort),
    .Y0_o        (y0_out),
    .Y1_o        (y1_out),
    .Y1_bits_o   (y1_bits),
    .cand_valid_o(cand_valid),
    .cand_ready_i(cand_ready),
    .busy_o      (busy),
    .done_o      (done),
    .count_o     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [63:0] y0, input logic [63:0] y1,
                        input logic [15:0] f, input logic [15:0] l);
    cfg_valid  = 1'b1;
    y0_in      = y0;
    y1_in      = y1;
    first_bits = f;
    last_bits  = l;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({cfg_ready, cand_valid, busy, done} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 1000", {cfg_ready, cand_valid, busy, done});
    end
    n_cmp++;
    if ({y0_out, y1_out, y1_bits, count} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got y0=%h y1=%h bits=%h count=%h required all zero",
               y0_out, y1_out, y1_bits, count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] exp_seq [4];
    int bad;
    exp_seq = '{16'h0003, 16'h0004, 16'h0005, 16'h0006};
    bad = 0;
    cand_ready = 1'b1;
    do_cfg(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0003, 16'h0006);
    for (int i = 0; i < 4; i++) begin
      if (y1_bits !== exp_seq[i] || cand_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
        bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL basic_seq: got %0d bad cycles required 0", bad);
    end
    n_cmp++;
    if ({done, cand_valid, busy, cfg_ready} !== 4'b1000 || count !== 17'd4) begin
      n_err++;
      $display("FAIL basic_done: got flags=%b count=%0d required 1000 count=4",
               {done, cand_valid, busy, cfg_ready}, count);
    end
    tick();
    n_cmp++;
    if (cfg_ready !== 1'b1 || done !== 1'b0 || count !== 17'd4) begin
      n_err++;
      $display("FAIL basic_idle: got cfg_ready=%b done=%b count=%0d required 1 0 4",
               cfg_ready, done, count);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  pat;
    logic [15:0] exp_bits;
    int hs;
    int bad;
    logic fin;
    pat = 4'b1001;  // ready per cycle: 1,0,0,1 (bit 0 first)
    hs = 0;
    bad = 0;
    fin = 1'b0;
    exp_bits = 16'h0003;
    do_cfg(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0003, 16'h0006);
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      cand_ready = pat[cyc % 4];
      if (cand_valid !== 1'b1 || y1_bits !== exp_bits || y0_out !== 64'h0 ||
          y1_out !== 64'hFFFF_FFFF_FFFF_FFFF)
        bad++;
      tick();
      if (cand_ready) begin
        hs++;
        if (exp_bits == 16'h0006) fin = 1'b1;
        else exp_bits = exp_bits + 16'h1;
      end
    end
    n_cmp++;
    if (bad != 0 || !fin) begin
      n_err++;
      $display("FAIL bp_stable: got %0d bad cycles finished=%b required 0 1", bad, fin);
    end
    n_cmp++;
    if (done !== 1'b1 || count !== 17'd4 || hs != 4) begin
      n_err++;
      $display("FAIL bp_count: got done=%b count=%0d hs=%0d required 1 4 4", done, count, hs);
    end
    cand_ready = 1'b1;
    tick();
  endtask

  task automatic test_wrap_single();
    logic [15:0] exp_seq [4];
    int bad;
    exp_seq = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    bad = 0;
    cand_ready = 1'b1;
    do_cfg(64'h1111, 64'h2222, 16'hFFFE, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      if (y1_bits !== exp_seq[i] || cand_valid !== 1'b1) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0 || done !== 1'b1 || count !== 17'd4) begin
      n_err++;
      $display("FAIL wrap: got bad=%0d done=%b count=%0d required 0 1 4", bad, done, count);
    end
    tick();
    do_cfg(64'h3333, 64'h4444, 16'h1234, 16'h1234);
    n_cmp++;
    if (y1_bits !== 16'h1234 || cand_valid !== 1'b1 || y0_out !== 64'h3333 ||
        y1_out !== 64'h4444) begin
      n_err++;
      $display("FAIL single_cand: got bits=%h valid=%b y0=%h y1=%h required 1234 1 3333 4444",
               y1_bits, cand_valid, y0_out, y1_out);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || count !== 17'd1 || cand_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: got done=%b count=%0d valid=%b required 1 1 0",
               done, count, cand_valid);
    end
    tick();
  endtask

  task automatic test_full_range();
    int bad;
    bad = 0;
    cand_ready = 1'b1;
    do_cfg(64'h0, 64'h1, 16'h0000, 16'hFFFF);
    for (int i = 0; i < 65536; i++) begin
      if (y1_bits !== 16'(i) || cand_valid !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL full_seq: got %0d bad cycles required 0", bad);
    end
    n_cmp++;
    if (done !== 1'b1 || count !== 17'h10000) begin
      n_err++;
      $display("FAIL full_done: got done=%b count=%h required 1 10000", done, count);
    end
    tick();
  endtask

  task automatic test_abort();
    cand_ready = 1'b1;
    do_cfg(64'h5, 64'h6, 16'h0000, 16'h00FF);
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (y1_bits !== 16'd10 || count !== 17'd10) begin
      n_err++;
      $display("FAIL abort_pre: got bits=%0d count=%0d required 10 10", y1_bits, count);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({cfg_ready, cand_valid, busy, done} !== 4'b1000 || count !== 17'd11) begin
      n_err++;
      $display("FAIL abort_idle: got flags=%b count=%0d required 1000 11",
               {cfg_ready, cand_valid, busy, done}, count);
    end
    // Abort in IDLE is ignored; the new configuration is taken straight away.
    abort = 1'b1;
    do_cfg(64'h7, 64'h8, 16'h0005, 16'h0005);
    abort = 1'b0;
    n_cmp++;
    if (cand_valid !== 1'b1 || y1_bits !== 16'h0005 || count !== 17'd0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_recfg: got valid=%b bits=%h count=%0d done=%b required 1 0005 0 0",
               cand_valid, y1_bits, count, done);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || count !== 17'd1) begin
      n_err++;
      $display("FAIL abort_next_done: got done=%b count=%0d required 1 1", done, count);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int bad;
    bad = 0;
    cand_ready = 1'b0;
    do_cfg(64'hAAAA, 64'hBBBB, 16'h0010, 16'h0020);
    cfg_valid  = 1'b1;
    y0_in      = 64'hDEAD;
    first_bits = 16'h0999;
    for (int i = 0; i < 3; i++) begin
      if (y0_out !== 64'hAAAA || y1_bits !== 16'h0010 || cfg_ready !== 1'b0 || busy !== 1'b1)
        bad++;
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL run_ignores_cfg: got %0d bad cycles required 0", bad);
    end
    cfg_valid = 1'b0;
    cand_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({cfg_ready, cand_valid, busy, done} !== 4'b1000 ||
        {y0_out, y1_out, y1_bits, count} !== '0) begin
      n_err++;
      $display("FAIL midrun_reset: got flags=%b y0=%h bits=%h count=%0d required 1000 and zeros",
               {cfg_ready, cand_valid, busy, done}, y0_out, y1_bits, count);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_after: got done=%b cfg_ready=%b required 0 1", done, cfg_ready);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    y0_in      = '0;
    y1_in      = '0;
    first_bits = '0;
    last_bits  = '0;
    abort      = 1'b0;
    cand_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_single();
    test_full_range();
    test_abort();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_select_sequencer.md
Name: output_select_sequencer

Overview:
- Sequences the 16-bit word-select pattern (Y1_bits) that drives the 1024-bit candidate builder.
- Takes one configuration (Y0 word, Y1 word, first/last select pattern), then steps the select pattern through the range, one pattern per accepted handshake.
- Presents each candidate to the downstream Skein hash core over a valid/ready handshake.
- Reports completion and the number of candidates issued.

Parameters:
- SEL_WIDTH, 16: width of the select pattern (one bit per 64-bit output word).
- WORD_WIDTH, 64: width of the Y0/Y1 words.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- cfg_valid_i  input  1  configuration offered.
- cfg_ready_o  output  1  sequencer can accept a configuration (high only in IDLE).
- Y0_i  input  WORD_WIDTH  word used where a select bit is 0.
- Y1_i  input  WORD_WIDTH  word used where a select bit is 1.
- first_bits_i  input  SEL_WIDTH  first select pattern to issue.
- last_bits_i  input  SEL_WIDTH  last select pattern to issue (inclusive).
- abort_i  input  1  cancel the current run.
- Y0_o  output  WORD_WIDTH  latched Y0 to the candidate builder.
- Y1_o  output  WORD_WIDTH  latched Y1 to the candidate builder.
- Y1_bits_o  output  SEL_WIDTH  current select pattern.
- cand_valid_o  output  1  current candidate is valid.
- cand_ready_i  input  1  hash core accepts the candidate.
- busy_o  output  1  high in RUN.
- done_o  output  1  one-cycle pulse when the last pattern is accepted.
- count_o  output  SEL_WIDTH+1  candidates accepted in the current or last run.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE.
  - Y0_o, Y1_o, Y1_bits_o, count_o = 0.
  - cand_valid_o, busy_o, done_o = 0.
  - cfg_ready_o=1 from the first cycle after reset.
  - rst_i overrides everything, including mid-run; no done_o pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_ready_o=1.
  - On cfg_valid_i=1: latch Y0_i→Y0_o, Y1_i→Y1_o, first_bits_i→Y1_bits_o, last_bits_i→internal last register; clear count_o; go to RUN.
  - count_o otherwise holds its previous value.
- RUN:
  - cand_valid_o=1 and busy_o=1 combinationally from state; first candidate is valid the cycle after the cfg handshake.
  - On cand_valid_o & cand_ready_i: count_o increments.
    - If Y1_bits_o == last, go to DONE; Y1_bits_o holds.
    - Otherwise Y1_bits_o <= Y1_bits_o + 1, modulo 2^SEL_WIDTH.
  - Wrap-around is legal: first > last iterates through all-ones then 0.
  - first == last issues exactly one candidate.
  - first = last + 1 (mod 2^SEL_WIDTH) issues the full 2^SEL_WIDTH patterns; count_o ends at 65536, hence the extra bit.
  - While cand_ready_i=0, Y0_o, Y1_o and Y1_bits_o are stable.
  - cfg_valid_i is ignored (cfg_ready_o=0).
  - Throughput is one candidate per cycle when cand_ready_i is held high.
- abort_i in RUN:
  - Go to IDLE next cycle; done_o is not pulsed.
  - If a handshake completes in the same cycle, it is counted and abort still wins over the DONE transition.
  - count_o holds the accepted total.
  - abort_i is ignored in IDLE and DONE.
- DONE:
  - done_o=1, cand_valid_o=0, busy_o=0, cfg_ready_o=0 for exactly one cycle; then go to IDLE.
- All outputs are registered, except cand_valid_o, busy_o and cfg_ready_o, which are decoded from the state register.

Test Plan:
- Basic run: reset; cfg Y0=0x0, Y1=0xFFFF_FFFF_FFFF_FFFF, first=0x0003, last=0x0006, cand_ready_i=1 → Y1_bits_o 3,4,5,6 on consecutive cycles; done_o pulses the cycle after 6 is accepted; count_o=4; cfg_ready_o back to 1 one cycle later.
- Backpressure: same cfg with cand_ready_i toggling 1,0,0,1,… → Y1_bits_o/Y0_o/Y1_o never change while valid & !ready; exactly 4 handshakes; count_o=4.
- Wrap: first=0xFFFE, last=0x0001 → sequence FFFE, FFFF, 0000, 0001; count_o=4. Single: first=last=0x1234 → one candidate; count_o=1.
- Full range: first=0x0000, last=0xFFFF, ready=1 → 65536 candidates; done_o after the last one; count_o=0x10000.
- Abort: run first=0, last=0x00FF; assert abort_i with ready=1 after the 10th acceptance → IDLE next cycle, no done_o, count_o=11; a new cfg is accepted immediately.
- Reset mid-run: rst_i during RUN → next cycle all outputs zero, cfg_ready_o=1, done_o never pulses; cfg_valid_i held during RUN is ignored.
